// File: rtl/mx_vector_packer.sv
// mx_vector_packer: assembles one scale beat plus BLOCK_SIZE element
// beats into the flat MX vector bus and presents it on valid/ready.
module mx_vector_packer #(
    parameter int BLOCK_SIZE = 32,
    parameter int OUT_W      = 264,
    parameter int SCALE_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [2:0]       in_fmt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_vector,
    output logic [2:0]       out_fmt,
    output logic             out_err
);

    localparam int CW = $clog2(BLOCK_SIZE);
    localparam int BW = CW + 3;
    localparam logic [CW-1:0] LAST = CW'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {
        S_SCALE,
        S_ELEM,
        S_OUT
    } state_t;

    state_t           state;
    logic [CW-1:0]    elem_cnt;
    logic [OUT_W-1:0] vec;
    logic [2:0]       fmt_q;
    logic             err_q;

    logic [2:0]       fmt_in;
    logic             fmt_bad;
    logic             in_is4;
    logic             in_is6;
    logic             q_is4;
    logic             q_is6;
    logic             elem_err;
    logic [BW-1:0]    base8;
    logic [BW-1:0]    base6;
    logic [BW-1:0]    base4;

    // Legalise the incoming format and decode element widths and slot offsets.
    always_comb begin
        fmt_bad  = (in_fmt > 3'd5);
        fmt_in   = fmt_bad ? 3'd5 : in_fmt;
        in_is4   = (fmt_in == 3'd4);
        in_is6   = (fmt_in == 3'd2) || (fmt_in == 3'd3);
        q_is4    = (fmt_q == 3'd4);
        q_is6    = (fmt_q == 3'd2) || (fmt_q == 3'd3);
        base8    = {elem_cnt, 3'b000};
        base4    = BW'({elem_cnt, 2'b00});
        base6    = BW'(elem_cnt) * BW'(6);
        elem_err = 1'b0;
        unique case (1'b1)
            q_is4:   elem_err = |in_data[7:4];
            q_is6:   elem_err = |in_data[7:6];
            default: elem_err = 1'b0;
        endcase
    end

    // Collection / output state machine with the packed vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_SCALE;
            elem_cnt <= '0;
            vec      <= '0;
            fmt_q    <= 3'd0;
            err_q    <= 1'b0;
        end else begin
            unique case (state)
                S_SCALE: begin
                    if (in_valid) begin
                        fmt_q    <= fmt_in;
                        err_q    <= fmt_bad;
                        elem_cnt <= '0;
                        vec      <= '0;
                        unique case (1'b1)
                            in_is4:
                                vec[BLOCK_SIZE*4 +: SCALE_W]
                                    <= in_data[SCALE_W-1:0];
                            in_is6:
                                vec[BLOCK_SIZE*6 +: SCALE_W]
                                    <= in_data[SCALE_W-1:0];
                            default:
                                vec[BLOCK_SIZE*8 +: SCALE_W]
                                    <= in_data[SCALE_W-1:0];
                        endcase
                        state <= S_ELEM;
                    end
                end
                S_ELEM: begin
                    if (in_valid) begin
                        unique case (1'b1)
                            q_is4:   vec[base4 +: 4] <= in_data[3:0];
                            q_is6:   vec[base6 +: 6] <= in_data[5:0];
                            default: vec[base8 +: 8] <= in_data;
                        endcase
                        if (elem_err) begin
                            err_q <= 1'b1;
                        end
                        if (elem_cnt == LAST) begin
                            elem_cnt <= '0;
                            state    <= S_OUT;
                        end else begin
                            elem_cnt <= elem_cnt + 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state <= S_SCALE;
                    end
                end
                default: state <= S_SCALE;
            endcase
        end
    end

    assign in_ready   = (state != S_OUT);
    assign out_valid  = (state == S_OUT);
    assign out_vector = vec;
    assign out_fmt    = fmt_q;
    assign out_err    = err_q;

endmodule

// File: tb/tb_mx_vector_packer.sv
// tb_mx_vector_packer: table-driven vectors with a scoreboard queue,
// plus stall, gap and mid-collection reset sequences.
module tb_mx_vector_packer;

    localparam int BS = 32;
    localparam int OW = 264;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'h00;
    logic [2:0]    in_fmt = 3'd0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_vector;
    logic [2:0]    out_fmt;
    logic          out_err;

    mx_vector_packer #(
        .BLOCK_SIZE(BS),
        .OUT_W(OW),
        .SCALE_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_fmt(in_fmt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_vector(out_vector),
        .out_fmt(out_fmt),
        .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] v;
        logic [2:0]    f;
        logic          e;
    } exp_t;

    typedef struct {
        logic [2:0] f;
        logic [7:0] s;
        int         kind;
        int         bad;
        logic [2:0] xf;
        logic       xe;
        int         stall;
        bit         gaps;
        bit         rr;
    } vec_t;

    int            errors = 0;
    int            checks = 0;
    exp_t          q[$];
    exp_t          mon_e;
    vec_t          tbl[10];
    logic [OW-1:0] last_vec = '0;
    logic [OW-1:0] hold_vec = '0;
    bit            hold_on = 0;
    int            stall = 0;
    bit            rand_rdy = 0;
    bit            gaps = 0;

    task automatic chk(input string name, input logic [OW-1:0] act,
                       input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int ew_of(input logic [2:0] f);
        if (f == 3'd4) return 4;
        if (f == 3'd2 || f == 3'd3) return 6;
        return 8;
    endfunction

    // Consumer ready: forced low while stall runs, else steady or random.
    always @(posedge clk) begin
        #2;
        if (stall > 0) begin
            out_ready = 1'b0;
            stall--;
        end else begin
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard pop on handshake, hold checks on stall.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!out_ready) begin
                chk("in_ready_low_in_out", OW'(in_ready), '0);
                if (hold_on) chk("out_hold_stable", out_vector, hold_vec);
                hold_vec = out_vector;
                hold_on  = 1;
            end else begin
                hold_on = 0;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_vector: got %h", out_vector);
                end else begin
                    mon_e = q.pop_front();
                    chk("out_vector", out_vector, mon_e.v);
                    chk("out_fmt", OW'(out_fmt), OW'(mon_e.f));
                    chk("out_err", OW'(out_err), OW'(mon_e.e));
                    last_vec = out_vector;
                end
            end
        end else begin
            hold_on = 0;
        end
    end

    task automatic beat(input logic [7:0] d, input logic [2:0] f);
        int t;
        int g;
        t = 0;
        @(negedge clk);
        if (gaps) begin
            g = $urandom_range(0, 2);
            repeat (g) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_fmt   = f;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: in_ready %b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_vector(input vec_t r);
        logic [7:0] el[BS];
        exp_t       e;
        logic [2:0] lf;
        int         ew;
        lf = (r.f > 3'd5) ? 3'd5 : r.f;
        ew = ew_of(lf);
        for (int i = 0; i < BS; i++) begin
            if (r.kind == 0) el[i] = 8'(i);
            else if (r.kind == 1) el[i] = 8'(i & 15);
            else el[i] = 8'($urandom) & 8'((1 << ew) - 1);
            if (i == r.bad) el[i] = 8'hC1;
        end
        e.v = '0;
        for (int i = 0; i < BS; i++)
            for (int b = 0; b < ew; b++)
                e.v[i*ew+b] = el[i][b];
        for (int b = 0; b < 8; b++)
            e.v[BS*ew+b] = r.s[b];
        e.f = r.xf;
        e.e = r.xe;
        beat(r.s, r.f);
        for (int i = 0; i < BS; i++) begin
            if (i == BS - 1) q.push_back(e);
            beat(el[i], 3'($urandom));
        end
        stall = r.stall;
        chk("out_valid_after_last", OW'(out_valid), OW'(1));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() > 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending %0d required 0", q.size());
            q.delete();
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_in_ready"}, OW'(in_ready), OW'(1));
        chk({tag, "_out_valid"}, OW'(out_valid), '0);
        chk({tag, "_out_vector"}, out_vector, '0);
        chk({tag, "_out_fmt"}, OW'(out_fmt), '0);
        chk({tag, "_out_err"}, OW'(out_err), '0);
    endtask

    initial begin
        tbl[0] = '{3'd5, 8'h7F, 0, -1, 3'd5, 1'b0, 0, 0, 0};
        tbl[1] = '{3'd4, 8'h02, 1, -1, 3'd4, 1'b0, 0, 0, 0};
        tbl[2] = '{3'd2, 8'h33, 2, 5, 3'd2, 1'b1, 0, 0, 0};
        tbl[3] = '{3'd2, 8'h44, 2, -1, 3'd2, 1'b0, 0, 0, 0};
        tbl[4] = '{3'd7, 8'h11, 0, -1, 3'd5, 1'b1, 0, 0, 0};
        tbl[5] = '{3'd0, 8'hA5, 2, -1, 3'd0, 1'b0, 10, 1, 0};
        tbl[6] = '{3'd1, 8'h5A, 2, -1, 3'd1, 1'b0, 0, 1, 1};
        tbl[7] = '{3'd3, 8'hC3, 2, 9, 3'd3, 1'b1, 0, 0, 1};
        tbl[8] = '{3'd6, 8'h0F, 2, -1, 3'd5, 1'b1, 0, 0, 0};
        tbl[9] = '{3'd4, 8'h80, 2, 31, 3'd4, 1'b1, 0, 0, 0};

        repeat (2) @(negedge clk);
        #1;
        chk_reset_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) begin
            gaps     = tbl[k].gaps;
            rand_rdy = tbl[k].rr;
            send_vector(tbl[k]);
            drain();
            if (k == 0) begin
                chk("int8_slot0", OW'(last_vec[7:0]), '0);
                chk("int8_slot31", OW'(last_vec[255:248]), OW'(8'h1F));
                chk("int8_scale", OW'(last_vec[263:256]), OW'(8'h7F));
            end
            if (k == 1) begin
                chk("e2m1_scale", OW'(last_vec[135:128]), OW'(8'h02));
                chk("e2m1_upper", OW'(last_vec[263:136]), '0);
                chk("e2m1_slot15", OW'(last_vec[63:60]), OW'(4'hF));
            end
            if (k == 2) begin
                chk("e3m2_slot5", OW'(last_vec[35:30]), OW'(6'h01));
            end
        end
        gaps     = 0;
        rand_rdy = 0;

        beat(8'h66, 3'd5);
        for (int i = 0; i < 12; i++) beat(8'(8'hE0 + i), 3'd5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        send_vector(tbl[0]);
        drain();
        chk("after_abort_scale", OW'(last_vec[263:256]), OW'(8'h7F));

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mx_vector_packer.md
Name: mx_vector_packer

Overview:
- Transmit-side assembler for MX vectors: accepts a byte stream of one shared scale beat followed by SCALING_BLOCK_SIZE element beats.
- Packs them into the flat LARGEST_VECTOR_SIZE bus consumed by the MX vector parsers, then presents the vector on a valid/ready output.
- Sits between the element/scale producer (quantizer or memory reader) and the MX ALU input.

Parameters:
- BLOCK_SIZE, 32 (SCALING_BLOCK_SIZE): elements per vector.
- OUT_W, 264 (LARGEST_VECTOR_SIZE): output bus width.
- SCALE_W, 8 (MX_SCALE_DATA_BITS): scale width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  packer can accept a beat.
- in_data  in  8  scale byte (first beat) or element, right-justified (element beats).
- in_fmt  in  3  format, sampled on scale beat only: 0 E5M2, 1 E4M3, 2 E3M2, 3 E2M3, 4 E2M1, 5 INT8, 6/7 illegal.
- out_valid  out  1  packed vector valid.
- out_ready  in  1  consumer accepts vector.
- out_vector  out  OUT_W  packed vector.
- out_fmt  out  3  format of out_vector (legalised).
- out_err  out  1  vector contained a format/width violation.

Behaviour:
- Interface: already decided — one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: all outputs 0, except in_ready=1; state=S_SCALE, elem_cnt=0, internal vector/fmt/err registers 0.
- Transfers: a beat transfers when in_valid&&in_ready; a vector transfers when out_valid&&out_ready.
- Element width EW: 8 for fmt 0,1,5; 6 for fmt 2,3; 4 for fmt 4.
- Packing:
  - element i occupies out_vector[i*EW +: EW];
  - scale occupies out_vector[BLOCK_SIZE*EW +: 8];
  - all bits above that are 0 (E2M1 uses bits 135:0, FP6 uses 199:0, 8-bit formats use 263:0).
- S_SCALE (in_ready=1): on transfer, latch scale and fmt, clear vector data, clear err, elem_cnt=0, go S_ELEM.
  - fmt 6/7: store fmt=5 (INT8 packing) and set err.
- S_ELEM (in_ready=1): on transfer, write in_data[EW-1:0] into slot elem_cnt.
  - If in_data[7:EW] != 0, set err; the truncated value is still packed.
  - elem_cnt increments; on the transfer with elem_cnt==BLOCK_SIZE-1, elem_cnt wraps to 0 and state goes S_OUT.
- S_OUT (in_ready=0): out_valid=1 with out_vector/out_fmt/out_err stable until out_ready; on transfer go S_SCALE next cycle.
  - out_valid asserts the cycle after the last element transfer.
- Throughput: 1 scale + 32 element cycles + ≥1 output cycle = minimum 34 cycles per vector; no overlap of output with next scale beat.
- in_valid low stalls in any input state with no state change; out_ready low holds S_OUT indefinitely.
- in_fmt is ignored outside scale beats; a mid-vector change has no effect.
- Reset asserted mid-collection or mid-output: immediate return to reset values; the partial vector is discarded, no out_valid pulse.
- out_ready in S_SCALE/S_ELEM is ignored.

Test Plan:
- INT8, scale 0x7F, elements i=0..31 → after 33 accepts, out_valid next cycle; out_vector[7:0]=0x00, [255:248]=0x1F, [263:256]=0x7F; out_fmt=5; out_err=0.
- E2M1, scale 0x02, element i = i&0xF → out_vector[i*4+:4]=i&0xF, [135:128]=0x02, [263:136]=0, out_err=0.
- E3M2, element 5 = 0xC1 (upper bits set) → slot 5 [35:30]=0x01, out_err=1; a clean E3M2 vector after it has out_err=0.
- fmt=7 on scale beat → packed as INT8, out_fmt=5, out_err=1.
- Random in_valid gaps plus out_ready low for 10 cycles → in_ready=0 throughout S_OUT, out_vector stable, next scale accepted only after the handshake.
- rst_n low after 12 element beats → outputs at reset values; a following full vector is packed with no residue from the aborted one.
